sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single external 16-bit SRAM between two requesters.
  - The CPU memory path: SRAM-bound accesses that the memory control unit did not decode as memory-mapped I/O.
  - A read-only video fetch port used by the display/text renderer.
- Owns the only SRAM control-signal sequencer in the design.
  - Multi-cycle access FSM.
  - Round-robin arbitration when both ports request.
  - Registered read-data return with a one-cycle completion pulse per port.

Parameters:
- ACCESS_CYCLES, default 2: cycles that CE and OE/WE stay asserted per access. Legal range is 1..15.
- ADDR_W, default 20: SRAM address width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- CPU_Req  in  1  CPU access request (level).
- CPU_R_W  in  1  1 = write, 0 = read.
- CPU_Addr  in  16  CPU word address, zero-extended to ADDR_W.
- CPU_WData  in  16  write data.
- CPU_RData  out  16  last CPU read data.
- CPU_Ready  out  1  one-cycle completion pulse.
- VID_Req  in  1  video read request (level).
- VID_Addr  in  ADDR_W  video word address.
- VID_RData  out  16  last video read data.
- VID_Valid  out  1  one-cycle completion pulse.
- SRAM_Addr  out  ADDR_W  SRAM address.
- SRAM_DQ_Out  out  16  data toward the SRAM tri-state.
- SRAM_DQ_In  in  16  data from the SRAM tri-state.
- SRAM_DQ_OE  out  1  tri-state drive enable.
- Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB  out  1 each  active-high SRAM strobes; inversion happens at top level.

Behaviour:
- Reset (Reset=0, async):
  - State goes to IDLE; counter = 0; last_grant = CPU.
  - All strobes, SRAM_DQ_OE, CPU_Ready and VID_Valid = 0.
  - CPU_RData, VID_RData, SRAM_Addr and SRAM_DQ_Out = 0.
  - Applies immediately even mid-access. The aborted access never completes and no pulse is emitted.
- FSM states: IDLE, ACCESS, COMPLETE.
- IDLE:
  - Requests are sampled only in this state.
  - Only VID_Req → grant video. Only CPU_Req → grant CPU.
  - Both → grant the port that is not last_grant. After reset this means video wins first.
  - On grant, latch port, address (CPU_Addr zero-extended), R_W (video is always read) and write data; clear the counter; go to ACCESS.
- ACCESS:
  - Mem_CE=1, Mem_LB=Mem_UB=1.
  - Read: Mem_OE=1.
  - Write: Mem_WE=1 and SRAM_DQ_OE=1.
  - Counter increments each cycle.
  - On the last cycle (counter == ACCESS_CYCLES-1), read data is captured from SRAM_DQ_In into the granted port's RData register at that edge; then go to COMPLETE.
- COMPLETE:
  - All strobes are 0.
  - SRAM_DQ_OE stays 1 for writes (data hold).
  - SRAM_Addr is held.
  - The granted port's Ready/Valid = 1 for exactly this cycle.
  - last_grant is updated to the granted port; go to IDLE.
- Latency: request high at IDLE edge t → completion pulse during cycle t+ACCESS_CYCLES+1.
  - Back-to-back throughput is ACCESS_CYCLES+2 cycles per access.
- Handshake:
  - A requester must drop Req no later than the cycle after its pulse; a registered drop is sufficient.
  - Req still high in IDLE is a new request.
  - Req dropped mid-access does not cancel the access; it completes and pulses normally.
- RData registers change only at completion of their own port's read. Writes never alter CPU_RData.
- SRAM_Addr and SRAM_DQ_Out hold their last values in IDLE.
- Starvation bound: neither port waits more than one foreign access.

Decomposition:
- Shared package elc3_mem_pkg holds:
  - state enum {IDLE, ACCESS, COMPLETE};
  - grant enum {GNT_CPU, GNT_VID};
  - constants SRAM_ADDR_W=20 and DATA_W=16.
- One sub-module, sram_access_timer: loadable cycle counter with a `last` flag, parameterised by ACCESS_CYCLES.

Test Plan (ACCESS_CYCLES=2):
1. CPU write to 0x3000 with data 0xBEEF → SRAM_Addr=0x03000; Mem_WE high 2 cycles; SRAM_DQ_OE high 3 cycles; CPU_Ready pulses in cycle 3 after the request edge; CE low in that cycle.
2. CPU read of 0x3000 with the SRAM model returning 0xBEEF → Mem_OE high 2 cycles; CPU_RData=0xBEEF when CPU_Ready=1; value held through a following CPU write.
3. CPU_Req and VID_Req (VID_Addr=0x80010) raised together after reset → video served first (VID_Valid cycle 3), then CPU (CPU_Ready cycle 7).
4. Both requests held continuously for 8 accesses → grants strictly alternate starting with video; no port sees two consecutive grants.
5. CPU_Req dropped in the first ACCESS cycle → access still completes; CPU_Ready pulses once; FSM returns to IDLE with no further grant.
6. Reset driven low in the second ACCESS cycle of a write → Mem_WE and SRAM_DQ_OE go 0 without waiting for a clock edge; no Ready pulse; after release, the first request is granted normally.

Source files
------------

// File: rtl/elc3_mem_pkg.sv
// Shared definitions for the external SRAM path.
//   state_e : arbiter sequencer states (IDLE, ACCESS, COMPLETE)
//   grant_e : which requester owns the current access
//   SRAM_ADDR_W / DATA_W : external SRAM geometry
//   CNT_W   : width of the access-cycle counter (ACCESS_CYCLES up to 15)
package elc3_mem_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int DATA_W      = 16;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_VID = 1'b1
  } grant_e;

endpackage

// File: rtl/sram_access_timer.sv
// Loadable cycle counter that times one SRAM access.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (counter -> 0)
//   clr_i  : clear the counter (start of a new access)
//   en_i   : advance the counter by one
//   last_o : high while the counter sits on the final access cycle
module sram_access_timer
  import elc3_mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_cycles
    $error("sram_access_timer: ACCESS_CYCLES must be 1..15");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/sram_arbiter.sv
// Shares the external 16-bit SRAM between the CPU memory path and the
// read-only video fetch port, and owns the SRAM strobe sequencer.
//   Clk, Reset            : clock, asynchronous active-low reset
//   CPU_Req/R_W/Addr/WData: CPU access request (level), 1 = write
//   CPU_RData, CPU_Ready  : last CPU read data, one-cycle completion pulse
//   VID_Req/Addr          : video read request (level) and word address
//   VID_RData, VID_Valid  : last video read data, one-cycle completion pulse
//   SRAM_Addr, SRAM_DQ_*  : SRAM address and data tri-state interface
//   Mem_CE/OE/WE/LB/UB    : active-high SRAM strobes (inverted at top level)
module sram_arbiter
  import elc3_mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W        = SRAM_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CPU_Req,
  input  logic              CPU_R_W,
  input  logic [15:0]       CPU_Addr,
  input  logic [15:0]       CPU_WData,
  output logic [15:0]       CPU_RData,
  output logic              CPU_Ready,
  input  logic              VID_Req,
  input  logic [ADDR_W-1:0] VID_Addr,
  output logic [15:0]       VID_RData,
  output logic              VID_Valid,
  output logic [ADDR_W-1:0] SRAM_Addr,
  output logic [15:0]       SRAM_DQ_Out,
  input  logic [15:0]       SRAM_DQ_In,
  output logic              SRAM_DQ_OE,
  output logic              Mem_CE,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              Mem_LB,
  output logic              Mem_UB
);

  state_e              state_q, state_d;
  grant_e              gnt_q, gnt_d;
  grant_e              last_q, last_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;
  logic                timer_clr, timer_en, timer_last;
  logic                pick_vid;
  logic                in_access, in_complete;

  // A lone request wins outright; on a tie the port that did not go last wins.
  assign pick_vid = VID_Req && (!CPU_Req || (last_q == GNT_CPU));

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (CPU_Req || VID_Req) begin
          timer_clr = 1'b1;
          state_d   = ACCESS;
          if (pick_vid) begin
            gnt_d  = GNT_VID;
            addr_d = VID_Addr;
            rw_d   = 1'b0;
          end else begin
            gnt_d   = GNT_CPU;
            addr_d  = ADDR_W'(CPU_Addr);
            rw_d    = CPU_R_W;
            wdata_d = CPU_WData;
          end
        end
      end
      ACCESS: begin
        timer_en = 1'b1;
        if (timer_last) begin
          state_d = COMPLETE;
          // Capture on the final strobed edge, while OE is still asserted.
          if (!rw_q) begin
            if (gnt_q == GNT_CPU) begin
              cpu_rdata_d = SRAM_DQ_In;
            end else begin
              vid_rdata_d = SRAM_DQ_In;
            end
          end
        end
      end
      COMPLETE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_CPU;
      last_q      <= GNT_CPU;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  sram_access_timer #(
    .ACCESS_CYCLES (ACCESS_CYCLES)
  ) u_timer (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .clr_i  (timer_clr),
    .en_i   (timer_en),
    .last_o (timer_last)
  );

  // Strobes decode straight from registered state so an asynchronous reset
  // drops them immediately, without waiting for a clock edge.
  assign in_access   = (state_q == ACCESS);
  assign in_complete = (state_q == COMPLETE);

  assign Mem_CE      = in_access;
  assign Mem_LB      = in_access;
  assign Mem_UB      = in_access;
  assign Mem_OE      = in_access && !rw_q;
  assign Mem_WE      = in_access && rw_q;
  // Keep driving write data through COMPLETE for hold time after WE drops.
  assign SRAM_DQ_OE  = rw_q && (in_access || in_complete);

  assign CPU_Ready   = in_complete && (gnt_q == GNT_CPU);
  assign VID_Valid   = in_complete && (gnt_q == GNT_VID);

  assign SRAM_Addr   = addr_q;
  assign SRAM_DQ_Out = wdata_q;
  assign CPU_RData   = cpu_rdata_q;
  assign VID_RData   = vid_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: directed table of single transactions,
// hand-written multi-cycle sequences, and randomized traffic checked against
// a transaction-level schedule model with its own memory image.
module tb_sram_arbiter;

  localparam int AC = 2;
  localparam int AW = 20;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          CPU_Req = 1'b0;
  logic          CPU_R_W = 1'b0;
  logic [15:0]   CPU_Addr = '0;
  logic [15:0]   CPU_WData = '0;
  logic [15:0]   CPU_RData;
  logic          CPU_Ready;
  logic          VID_Req = 1'b0;
  logic [AW-1:0] VID_Addr = '0;
  logic [15:0]   VID_RData;
  logic          VID_Valid;
  logic [AW-1:0] SRAM_Addr;
  logic [15:0]   SRAM_DQ_Out;
  logic [15:0]   SRAM_DQ_In;
  logic          SRAM_DQ_OE;
  logic          Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB;

  always #5 Clk = ~Clk;

  sram_arbiter #(
    .ACCESS_CYCLES (AC),
    .ADDR_W        (AW)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .CPU_Req     (CPU_Req),
    .CPU_R_W     (CPU_R_W),
    .CPU_Addr    (CPU_Addr),
    .CPU_WData   (CPU_WData),
    .CPU_RData   (CPU_RData),
    .CPU_Ready   (CPU_Ready),
    .VID_Req     (VID_Req),
    .VID_Addr    (VID_Addr),
    .VID_RData   (VID_RData),
    .VID_Valid   (VID_Valid),
    .SRAM_Addr   (SRAM_Addr),
    .SRAM_DQ_Out (SRAM_DQ_Out),
    .SRAM_DQ_In  (SRAM_DQ_In),
    .SRAM_DQ_OE  (SRAM_DQ_OE),
    .Mem_CE      (Mem_CE),
    .Mem_OE      (Mem_OE),
    .Mem_WE      (Mem_WE),
    .Mem_LB      (Mem_LB),
    .Mem_UB      (Mem_UB)
  );

  // SRAM model: 4K words indexed by the low address bits; unwritten words
  // return a fixed pattern, and the bus reads 0xDEAD when OE is not asserted.
  logic [15:0] sram [0:4095];
  bit          wv   [0:4095];

  function automatic logic [15:0] init_word(input logic [11:0] i);
    return {i[3:0], i} ^ 16'hC3A5;
  endfunction

  assign SRAM_DQ_In = (Mem_CE && Mem_OE) ?
                      (wv[SRAM_Addr[11:0]] ? sram[SRAM_Addr[11:0]] : init_word(SRAM_Addr[11:0])) :
                      16'hDEAD;

  always @(posedge Clk) begin
    if (Mem_CE && Mem_WE && SRAM_DQ_OE) begin
      sram[SRAM_Addr[11:0]] <= SRAM_DQ_Out;
      wv[SRAM_Addr[11:0]]   <= 1'b1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset   = 1'b0;
    CPU_Req = 1'b0;
    VID_Req = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  typedef struct {
    bit          vid;
    bit          wr;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic [19:0] exp_sa;
    int          exp_we;
    int          exp_oe;
    int          exp_dqoe;
  } vec_t;

  vec_t vt [8];
  logic [15:0] mcpu = '0;
  logic [15:0] mvid = '0;

  // One isolated transaction; cycle 1 is the first cycle after the sampling edge.
  task automatic run_vec(input string nm, input vec_t v);
    int nwe = 0, noe = 0, ndq = 0, npulse = 0, noth = 0, pc = 0;
    logic ce_p = 1'b1;
    logic [15:0] rd_p = '0, dq1 = '0;
    logic [19:0] sa1 = '0;
    logic own, oth;
    @(negedge Clk);
    if (v.vid) begin
      VID_Addr = v.addr;
      VID_Req  = 1'b1;
    end else begin
      CPU_Addr  = v.addr[15:0];
      CPU_R_W   = v.wr;
      CPU_WData = v.wdata;
      CPU_Req   = 1'b1;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      nwe += int'(Mem_WE);
      noe += int'(Mem_OE);
      ndq += int'(SRAM_DQ_OE);
      if (c == 1) begin
        sa1 = SRAM_Addr;
        dq1 = SRAM_DQ_Out;
      end
      own = v.vid ? VID_Valid : CPU_Ready;
      oth = v.vid ? CPU_Ready : VID_Valid;
      if (own) begin
        npulse++;
        if (pc == 0) begin
          pc   = c;
          ce_p = Mem_CE;
          rd_p = v.vid ? VID_RData : CPU_RData;
        end
        CPU_Req = 1'b0;
        VID_Req = 1'b0;
      end
      if (oth) noth++;
    end
    if (!v.wr) begin
      if (v.vid) mvid = v.exp_rd;
      else       mcpu = v.exp_rd;
    end
    chk({nm, "_latency"}, 32'(pc), 32'(AC + 1));
    chk({nm, "_npulse"},  32'(npulse), 32'd1);
    chk({nm, "_other"},   32'(noth), 32'd0);
    chk({nm, "_we_cyc"},  32'(nwe), 32'(v.exp_we));
    chk({nm, "_oe_cyc"},  32'(noe), 32'(v.exp_oe));
    chk({nm, "_dqoe_cyc"}, 32'(ndq), 32'(v.exp_dqoe));
    chk({nm, "_addr"},    32'(sa1), 32'(v.exp_sa));
    chk({nm, "_ce_pulse"}, 32'(ce_p), 32'd0);
    if (v.wr) chk({nm, "_dq_out"}, 32'(dq1), 32'(v.wdata));
    else      chk({nm, "_rd_at_pulse"}, 32'(rd_p), 32'(v.exp_rd));
    chk({nm, "_cpu_rdata"}, 32'(CPU_RData), 32'(mcpu));
    chk({nm, "_vid_rdata"}, 32'(VID_RData), 32'(mvid));
  endtask

  // Random-phase model state
  logic [15:0] ref_mem [int];
  bit          busy, cur_vid, cur_wr, last_vid, in_acc, in_cmp;
  bit          creq, vreq, cpend, vpend;
  int          g, free_at, cgap, vgap;
  logic [19:0] cur_addr, e_sa;
  logic [15:0] cur_wd, cur_rd, ecpu, evid;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          np, pc, nce, nrd, nvv;
    int          pcyc [8];
    bit          pvid [8];
    logic [15:0] rd;
    logic [11:0] idx;

    vt[0] = '{0, 1, 20'h03000, 16'hBEEF, 16'h0000, 20'h03000, 2, 0, 3};
    vt[1] = '{0, 0, 20'h03000, 16'h0000, 16'hBEEF, 20'h03000, 0, 2, 0};
    vt[2] = '{0, 1, 20'h03000, 16'h1111, 16'h0000, 20'h03000, 2, 0, 3};
    vt[3] = '{1, 0, 20'h80010, 16'h0000, 16'hC3B5, 20'h80010, 0, 2, 0};
    vt[4] = '{0, 1, 20'h0FFFF, 16'h1234, 16'h0000, 20'h0FFFF, 2, 0, 3};
    vt[5] = '{1, 0, 20'hFFFFF, 16'h0000, 16'h1234, 20'hFFFFF, 0, 2, 0};
    vt[6] = '{0, 0, 20'h0FFFF, 16'h0000, 16'h1234, 20'h0FFFF, 0, 2, 0};
    vt[7] = '{0, 0, 20'h03000, 16'h0000, 16'h1111, 20'h03000, 0, 2, 0};

    // Reset state
    do_reset();
    @(negedge Clk);
    chk("reset_ctrl", 32'({Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB, SRAM_DQ_OE, CPU_Ready, VID_Valid}), 32'd0);
    chk("reset_addr", 32'(SRAM_Addr), 32'd0);
    chk("reset_dq_out", 32'(SRAM_DQ_Out), 32'd0);
    chk("reset_rdata", {CPU_RData, VID_RData}, 32'd0);

    // Directed single transactions
    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Simultaneous requests after reset, then both held for 8 accesses
    do_reset();
    @(negedge Clk);
    VID_Addr = 20'h80010;
    CPU_Addr = 16'h3000;
    CPU_R_W  = 1'b0;
    CPU_Req  = 1'b1;
    VID_Req  = 1'b1;
    np = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (CPU_Ready && VID_Valid) chk("alt_both_pulse", 32'd1, 32'd0);
      if (CPU_Ready || VID_Valid) begin
        if (np < 8) begin
          pcyc[np] = c;
          pvid[np] = VID_Valid;
        end
        np++;
        if (np == 8) begin
          CPU_Req = 1'b0;
          VID_Req = 1'b0;
        end
      end
    end
    chk("alt_count", 32'(np), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("alt_cycle%0d", k), 32'(pcyc[k]), 32'((AC + 1) + (AC + 2) * k));
      chk($sformatf("alt_port%0d", k), 32'(pvid[k]), 32'((k % 2) == 0));
    end
    chk("alt_cpu_rdata", 32'(CPU_RData), 32'h1111);
    chk("alt_vid_rdata", 32'(VID_RData), 32'hC3B5);

    // Request dropped during the first access cycle
    @(negedge Clk);
    CPU_Addr = 16'hFFFF;
    CPU_R_W  = 1'b0;
    CPU_Req  = 1'b1;
    np = 0; pc = 0; nce = 0; nvv = 0; rd = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (c == 1) CPU_Req = 1'b0;
      nce += int'(Mem_CE);
      nvv += int'(VID_Valid);
      if (CPU_Ready) begin
        np++;
        pc = c;
        rd = CPU_RData;
      end
    end
    chk("drop_npulse", 32'(np), 32'd1);
    chk("drop_latency", 32'(pc), 32'(AC + 1));
    chk("drop_ce_cycles", 32'(nce), 32'(AC));
    chk("drop_rdata", 32'(rd), 32'h1234);
    chk("drop_vid_pulse", 32'(nvv), 32'd0);

    // Reset asserted in the second access cycle of a write
    @(negedge Clk);
    CPU_Addr  = 16'h00AA;
    CPU_R_W   = 1'b1;
    CPU_WData = 16'h5555;
    CPU_Req   = 1'b1;
    repeat (2) @(negedge Clk);
    chk("abort_we_before", 32'({Mem_WE, SRAM_DQ_OE}), 32'b11);
    #1 Reset = 1'b0;
    #1;
    chk("abort_we_async", 32'({Mem_CE, Mem_WE, SRAM_DQ_OE}), 32'd0);
    chk("abort_addr", 32'(SRAM_Addr), 32'd0);
    chk("abort_rdata", 32'(CPU_RData), 32'd0);
    CPU_Req = 1'b0;
    nrd = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      nrd += int'(CPU_Ready);
    end
    chk("abort_no_ready", 32'(nrd), 32'd0);
    Reset = 1'b1;
    mcpu = '0;
    mvid = '0;
    run_vec("after_abort", vt[7]);

    // Randomized traffic against the schedule model
    do_reset();
    busy = 0; last_vid = 0; free_at = 0; g = 0;
    creq = 0; vreq = 0; cpend = 0; vpend = 0; cgap = 0; vgap = 0;
    ecpu = '0; evid = '0; e_sa = '0;
    cur_vid = 0; cur_wr = 0; cur_addr = '0; cur_wd = '0; cur_rd = '0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge Clk);
      in_acc = busy && (c >= g + 1) && (c <= g + AC);
      in_cmp = busy && (c == g + AC + 1);
      if (in_cmp && !cur_wr) begin
        if (cur_vid) evid = cur_rd;
        else         ecpu = cur_rd;
      end
      chk("rnd_strobes", 32'({Mem_CE, Mem_LB, Mem_UB, Mem_OE, Mem_WE, SRAM_DQ_OE}),
          32'({in_acc, in_acc, in_acc, in_acc && !cur_wr, in_acc && cur_wr, (in_acc || in_cmp) && cur_wr}));
      chk("rnd_pulse", 32'({CPU_Ready, VID_Valid}), 32'({in_cmp && !cur_vid, in_cmp && cur_vid}));
      chk("rnd_addr", 32'(SRAM_Addr), 32'(e_sa));
      chk("rnd_rdata", {CPU_RData, VID_RData}, {ecpu, evid});
      if ((in_acc || in_cmp) && cur_wr) chk("rnd_dq_out", 32'(SRAM_DQ_Out), 32'(cur_wd));

      if (in_acc && ($urandom_range(0, 3) == 0)) begin
        if (cur_vid) vreq = 0;
        else         creq = 0;
      end
      if (in_cmp) begin
        busy = 0;
        if (cur_vid) begin
          vreq = 0; vpend = 0; vgap = $urandom_range(0, 3);
        end else begin
          creq = 0; cpend = 0; cgap = $urandom_range(0, 3);
        end
      end
      if (!cpend && !(in_cmp && !cur_vid)) begin
        if (cgap > 0) cgap--;
        else if ($urandom_range(0, 2) != 0) begin
          CPU_Addr  = {4'($urandom_range(0, 15)), 12'(256 + $urandom_range(0, 63))};
          CPU_R_W   = 1'($urandom_range(0, 1));
          CPU_WData = 16'($urandom);
          creq = 1; cpend = 1;
        end
      end
      if (!vpend && !(in_cmp && cur_vid)) begin
        if (vgap > 0) vgap--;
        else if ($urandom_range(0, 2) != 0) begin
          VID_Addr = {8'($urandom_range(0, 255)), 12'(256 + $urandom_range(0, 63))};
          vreq = 1; vpend = 1;
        end
      end
      CPU_Req = creq;
      VID_Req = vreq;

      if (!busy && (c >= free_at) && (creq || vreq)) begin
        cur_vid  = vreq && (!creq || !last_vid);
        last_vid = cur_vid;
        g        = c;
        free_at  = c + AC + 2;
        busy     = 1;
        if (cur_vid) begin
          cur_addr = VID_Addr;
          cur_wr   = 0;
        end else begin
          cur_addr = {4'b0000, CPU_Addr};
          cur_wr   = CPU_R_W;
          cur_wd   = CPU_WData;
        end
        e_sa = cur_addr;
        idx  = cur_addr[11:0];
        if (cur_wr) ref_mem[int'(idx)] = cur_wd;
        else cur_rd = ref_mem.exists(int'(idx)) ? ref_mem[int'(idx)] : init_word(idx);
      end
    end
    CPU_Req = 1'b0;
    VID_Req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
